// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the sequential ALU.
// Imported by the ALU top, its multiplier core and the bench.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LDA  = 4'h2;
  localparam logic [3:0] OP_CMA  = 4'h3;
  localparam logic [3:0] OP_CIR  = 4'h4;
  localparam logic [3:0] OP_CIL  = 4'h5;
  localparam logic [3:0] OP_TAC  = 4'h6;
  localparam logic [3:0] OP_NOP  = 4'h7;
  localparam logic [3:0] OP_SUB  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_INC  = 4'hB;
  localparam logic [3:0] OP_CLE  = 4'hC;
  localparam logic [3:0] OP_CME  = 4'hD;
  localparam logic [3:0] OP_MUL  = 4'hE;
  localparam logic [3:0] OP_NOP2 = 4'hF;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Control-unit handshake and result bus of the sequential ALU.
// master drives requests, slave is the ALU.
interface alu_seq_if #(
  parameter int W = 16
) ();

  logic         start;
  logic [3:0]   op_select;
  logic [W-1:0] AC_input;
  logic [W-1:0] DR_input;
  logic         busy;
  logic         done;
  logic [W-1:0] ALU_out;
  logic         E;
  logic         CO;
  logic         OVF;
  logic         N;
  logic         Z;

  modport master (
    output start, op_select, AC_input, DR_input,
    input  busy, done, ALU_out, E, CO, OVF, N, Z
  );

  modport slave (
    input  start, op_select, AC_input, DR_input,
    output busy, done, ALU_out, E, CO, OVF, N, Z
  );

endinterface

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier core, one partial product per step.
// prod includes the current step's addend so the last step is visible.
module alu_seq_mul
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           step,
  output logic [2*W-1:0] prod,
  output logic           last
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
    end else if (step) begin
      acc    <= prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (!last) cnt <= cnt + 1'b1;
    end
  end

  assign prod = acc + (mplier[0] ? mcand : '0);
  assign last = (cnt == CNT_LAST);

endmodule

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with internal E flip-flop.
// Single-cycle ops finish next edge; MUL iterates W steps.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic   clk,
  input  logic   rst,
  alu_seq_if.slave bus
);

  state_t state;
  state_t state_nx;

  logic [W-1:0] ac;
  logic [W-1:0] dr;
  logic [W:0]   sum_add;
  logic [W:0]   sum_sub;
  logic [W:0]   sum_inc;

  logic [W-1:0] sc_res;
  logic         sc_e;
  logic         sc_co;
  logic         sc_ovf;

  logic [W-1:0] nx_res;
  logic         nx_e;
  logic         nx_co;
  logic         nx_ovf;
  logic         wr;

  logic           mul_load;
  logic           mul_step;
  logic           mul_last;
  logic [2*W-1:0] mul_prod;

  logic [W-1:0] out_q;
  logic         e_q;
  logic         co_q;
  logic         ovf_q;
  logic         done_q;

  assign ac = bus.AC_input;
  assign dr = bus.DR_input;

  assign sum_add = {1'b0, ac} + {1'b0, dr};
  assign sum_sub = {1'b0, ac} + {1'b0, ~dr}
                 + {{W{1'b0}}, 1'b1};
  assign sum_inc = {1'b0, ac} + {{W{1'b0}}, 1'b1};

  always_comb begin
    sc_res = '0;
    sc_e   = e_q;
    sc_co  = 1'b0;
    sc_ovf = 1'b0;
    unique case (bus.op_select)
      OP_AND: sc_res = ac & dr;
      OP_ADD: begin
        sc_res = sum_add[W-1:0];
        sc_co  = sum_add[W];
        sc_e   = sum_add[W];
        sc_ovf = (ac[W-1] == dr[W-1])
              && (sum_add[W-1] != ac[W-1]);
      end
      OP_LDA: sc_res = dr;
      OP_CMA: sc_res = ~ac;
      OP_CIR: begin
        sc_res = {e_q, ac[W-1:1]};
        sc_e   = ac[0];
      end
      OP_CIL: begin
        sc_res = {ac[W-2:0], e_q};
        sc_e   = ac[W-1];
      end
      OP_TAC: sc_res = ac;
      OP_SUB: begin
        sc_res = sum_sub[W-1:0];
        sc_co  = sum_sub[W];
        sc_e   = sum_sub[W];
        sc_ovf = (ac[W-1] != dr[W-1])
              && (sum_sub[W-1] != ac[W-1]);
      end
      OP_OR:  sc_res = ac | dr;
      OP_XOR: sc_res = ac ^ dr;
      OP_INC: begin
        sc_res = sum_inc[W-1:0];
        sc_co  = sum_inc[W];
        sc_e   = sum_inc[W];
        // The implicit +1 operand is positive.
        sc_ovf = !ac[W-1] && sum_inc[W-1];
      end
      OP_CLE: begin
        sc_res = ac;
        sc_e   = 1'b0;
      end
      OP_CME: begin
        sc_res = ac;
        sc_e   = ~e_q;
      end
      OP_NOP, OP_MUL, OP_NOP2: sc_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    mul_load = 1'b0;
    mul_step = 1'b0;
    wr       = 1'b0;
    nx_res   = sc_res;
    nx_e     = sc_e;
    nx_co    = sc_co;
    nx_ovf   = sc_ovf;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.op_select == OP_MUL) begin
            mul_load = 1'b1;
            state_nx = S_MUL;
          end else begin
            wr = 1'b1;
          end
        end
      end
      S_MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          wr       = 1'b1;
          state_nx = S_IDLE;
          nx_res   = mul_prod[W-1:0];
          nx_e     = e_q;
          nx_co    = 1'b0;
          nx_ovf   = |mul_prod[2*W-1:W];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      e_q    <= 1'b0;
      co_q   <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= wr;
      if (wr) begin
        out_q <= nx_res;
        e_q   <= nx_e;
        co_q  <= nx_co;
        ovf_q <= nx_ovf;
      end
    end
  end

  alu_seq_mul #(.W(W)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .load (mul_load),
    .a    (ac),
    .b    (dr),
    .step (mul_step),
    .prod (mul_prod),
    .last (mul_last)
  );

  assign bus.busy    = (state == S_MUL);
  assign bus.done    = done_q;
  assign bus.ALU_out = out_q;
  assign bus.E       = e_q;
  assign bus.CO      = co_q;
  assign bus.OVF     = ovf_q;
  assign bus.N       = out_q[W-1];
  assign bus.Z       = (out_q == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq at W=16.
// Expected results come from an integer-arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.W(W)) bus ();

  alu_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic        m_e;
  logic [15:0] x_r;
  logic        x_e;
  logic        x_co;
  logic        x_ovf;

  logic [20:0] obs;
  assign obs = {bus.ALU_out, bus.E, bus.CO,
                bus.OVF, bus.N, bus.Z};

  function automatic logic [20:0] xv();
    return {x_r, x_e, x_co, x_ovf,
            x_r[15], (x_r == 16'h0)};
  endfunction

  function automatic void ref_op(
    input  logic [3:0]  op,
    input  logic [15:0] ac,
    input  logic [15:0] dr,
    input  logic        e_in,
    output logic [15:0] r,
    output logic        e_o,
    output logic        co,
    output logic        ovf
  );
    int u;
    int s;
    longint p;
    r = 16'h0; e_o = e_in; co = 1'b0; ovf = 1'b0;
    case (op)
      4'h0: r = ac & dr;
      4'h1: begin
        u = int'(ac) + int'(dr);
        s = int'($signed(ac)) + int'($signed(dr));
        r = u[15:0]; co = (u > 65535);
        ovf = (s > 32767) || (s < -32768);
        e_o = co;
      end
      4'h2: r = dr;
      4'h3: r = ~ac;
      4'h4: begin
        r = (ac >> 1) | (e_in ? 16'h8000 : 16'h0);
        e_o = (ac % 2) == 1;
      end
      4'h5: begin
        r = (ac << 1) | (e_in ? 16'h0001 : 16'h0);
        e_o = ac >= 16'h8000;
      end
      4'h6: r = ac;
      4'h8: begin
        u = int'(ac) - int'(dr);
        s = int'($signed(ac)) - int'($signed(dr));
        r = u[15:0]; co = (ac >= dr);
        ovf = (s > 32767) || (s < -32768);
        e_o = co;
      end
      4'h9: r = ac | dr;
      4'hA: r = ac ^ dr;
      4'hB: begin
        u = int'(ac) + 1;
        r = u[15:0]; co = (u > 65535);
        ovf = (ac == 16'h7FFF);
        e_o = co;
      end
      4'hC: begin r = ac; e_o = 1'b0; end
      4'hD: begin r = ac; e_o = ~e_in; end
      4'hE: begin
        p = longint'(ac) * longint'(dr);
        r = p[15:0]; ovf = (p > 65535);
      end
      default: r = 16'h0;
    endcase
  endfunction

  task automatic issue(input logic [3:0] op,
                       input logic [15:0] ac,
                       input logic [15:0] dr);
    bus.start = 1'b1;
    bus.op_select = op;
    bus.AC_input = ac;
    bus.DR_input = dr;
    ref_op(op, ac, dr, m_e, x_r, x_e, x_co, x_ovf);
    m_e = x_e;
  endtask

  task automatic step_single(input logic [3:0] op,
                             input logic [15:0] ac,
                             input logic [15:0] dr);
    issue(op, ac, dr);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_mul(input logic [15:0] ac,
                         input logic [15:0] dr,
                         input int pulse_at,
                         output int done_at,
                         output int busy_cnt);
    issue(OP_MUL, ac, dr);
    done_at = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.start = (k == pulse_at);
      if (k == pulse_at) begin
        bus.op_select = OP_ADD;
        bus.AC_input = 16'($urandom);
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_at = k;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op_select = 4'h0;
    bus.AC_input = 16'h0;
    bus.DR_input = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_e = 1'b0;
    n_checks++;
    if (obs !== {16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h",
               obs, {16'h0, 5'b00001});
    end
    n_checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_handshake: got %b want 00",
               {bus.busy, bus.done});
    end
  endtask

  task automatic test_add();
    step_single(OP_ADD, 16'h7FFF, 16'h0001);
    n_checks++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL add_done: got %b want 1", bus.done);
    end
    n_checks++;
    if (obs !== {16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL add_ovf: got %h want %h",
               obs, {16'h8000, 5'b00110});
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL add_done_pulse: got %b want 0", bus.done);
    end
  endtask

  task automatic test_sub();
    step_single(OP_SUB, 16'h0005, 16'h0007);
    n_checks++;
    if (obs !== {16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_borrow: got %h want %h",
               obs, {16'hFFFE, 5'b00010});
    end
    step_single(OP_SUB, 16'h0007, 16'h0005);
    n_checks++;
    if (obs !== {16'h0002, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_noborrow: got %h want %h",
               obs, {16'h0002, 5'b11000});
    end
  endtask

  task automatic test_e_ops();
    step_single(OP_CLE, 16'h1234, 16'h0);
    n_checks++;
    if ({bus.ALU_out, bus.E} !== {16'h1234, 1'b0}) begin
      n_fail++;
      $display("FAIL cle: got %h want %h",
               {bus.ALU_out, bus.E}, {16'h1234, 1'b0});
    end
    step_single(OP_CME, 16'h0000, 16'h0);
    n_checks++;
    if ({bus.E, bus.Z} !== 2'b11) begin
      n_fail++;
      $display("FAIL cme: got %b want 11", {bus.E, bus.Z});
    end
    step_single(OP_CIR, 16'h0001, 16'h0);
    n_checks++;
    if ({bus.ALU_out, bus.E} !== {16'h8000, 1'b1}) begin
      n_fail++;
      $display("FAIL cir: got %h want %h",
               {bus.ALU_out, bus.E}, {16'h8000, 1'b1});
    end
    step_single(OP_CIL, 16'h8000, 16'h0);
    n_checks++;
    if ({bus.ALU_out, bus.E} !== {16'h0001, 1'b1}) begin
      n_fail++;
      $display("FAIL cil: got %h want %h",
               {bus.ALU_out, bus.E}, {16'h0001, 1'b1});
    end
  endtask

  task automatic test_mul();
    int done_at;
    int busy_cnt;
    run_mul(16'h0100, 16'h0100, 0, done_at, busy_cnt);
    n_checks++;
    if (done_at !== W + 1 || busy_cnt !== W) begin
      n_fail++;
      $display("FAIL mul_latency: got done@%0d busy=%0d want %0d/%0d",
               done_at, busy_cnt, W + 1, W);
    end
    n_checks++;
    if (obs !== {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mul_wrap: got %h want %h",
               obs, {16'h0000, 5'b10101});
    end
    run_mul(16'h0003, 16'h0005, 0, done_at, busy_cnt);
    n_checks++;
    if (obs !== {16'h000F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mul_small: got %h want %h",
               obs, {16'h000F, 5'b10000});
    end
  endtask

  task automatic test_busy_start();
    int done_at;
    int busy_cnt;
    int extra;
    run_mul(16'($urandom), 16'($urandom), 5,
            done_at, busy_cnt);
    n_checks++;
    if (done_at !== W + 1) begin
      n_fail++;
      $display("FAIL busy_start_latency: got %0d want %0d",
               done_at, W + 1);
    end
    n_checks++;
    if (obs !== xv()) begin
      n_fail++;
      $display("FAIL busy_start_result: got %h want %h",
               obs, xv());
    end
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL busy_start_extra_done: got %0d want 0",
               extra);
    end
  endtask

  task automatic test_back_to_back();
    int done_at;
    int busy_cnt;
    logic [3:0] op;
    run_mul(16'($urandom), 16'($urandom), 0,
            done_at, busy_cnt);
    step_single(OP_ADD, 16'($urandom), 16'($urandom));
    n_checks++;
    if (bus.done !== 1'b1 || obs !== xv()) begin
      n_fail++;
      $display("FAIL b2b_after_mul: got %b/%h want 1/%h",
               bus.done, obs, xv());
    end
    for (int i = 0; i < 12; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == OP_MUL) op = OP_XOR;
      step_single(op, 16'($urandom), 16'($urandom));
      n_checks++;
      if (bus.done !== 1'b1 || obs !== xv()) begin
        n_fail++;
        $display("FAIL b2b_op%h: got %b/%h want 1/%h",
                 op, bus.done, obs, xv());
      end
    end
  endtask

  task automatic test_random();
    int done_at;
    int busy_cnt;
    logic [3:0] op;
    logic [15:0] a;
    logic [15:0] b;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 4 == 0) a = (i % 8 == 0) ? 16'hFFFF : 16'h7FFF;
      if (op == OP_MUL) begin
        run_mul(a, b, 0, done_at, busy_cnt);
        n_checks++;
        if (done_at !== W + 1) begin
          n_fail++;
          $display("FAIL rand_mul_latency: got %0d want %0d",
                   done_at, W + 1);
        end
      end else begin
        step_single(op, a, b);
      end
      n_checks++;
      if (bus.done !== 1'b1 || obs !== xv()) begin
        n_fail++;
        $display("FAIL rand_op%h a=%h b=%h: got %b/%h want 1/%h",
                 op, a, b, bus.done, obs, xv());
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    int dones;
    if (!m_e) step_single(OP_CME, 16'h0, 16'h0);
    step_single(OP_TAC, 16'hA5A5, 16'h0);
    issue(OP_MUL, 16'h00FF, 16'h0101);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 8) rst = 1'b1;
    end
    rst = 1'b0;
    m_e = 1'b0;
    n_checks++;
    if (obs !== {16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}
        || {bus.busy, bus.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_mul_reset: got %h/%b want %h/00",
               obs, {bus.busy, bus.done}, {16'h0, 5'b00001});
    end
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL mid_mul_no_done: got %0d want 0", dones);
    end
    step_single(OP_ADD, 16'($urandom), 16'($urandom));
    n_checks++;
    if (bus.done !== 1'b1 || obs !== xv()) begin
      n_fail++;
      $display("FAIL add_after_reset: got %b/%h want 1/%h",
               bus.done, obs, xv());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_e_ops();
    test_mul();
    test_busy_start();
    test_back_to_back();
    test_random();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
